// File: rtl/chi_link_pkg.sv
// Shared definitions for the CHI link-layer receive endpoint:
// link states, LCrdReturn opcode, credit limit and byte parity helper.
package chi_link_pkg;

    typedef enum logic [1:0] {
        STOP  = 2'd0,
        ACT   = 2'd1,
        RUN   = 2'd2,
        DEACT = 2'd3
    } link_state_e;

    localparam int unsigned LCRD_RETURN_OPC = 0;
    localparam int unsigned CHI_MAX_CRD     = 15;

    // Odd parity: the check bit makes the total count of ones odd.
    function automatic logic byte_par(input logic [7:0] b);
        return ~^b;
    endfunction

endpackage

// File: rtl/chi_rx_fifo.sv
// Synchronous FIFO holding received flits (payload plus parity-error bit).
// Depth need not be a power of two; pointers wrap explicitly.
module chi_rx_fifo
    import chi_link_pkg::*;
#(
    parameter int DEPTH = 15,
    parameter int W     = 129,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [W-1:0]  push_data,
    input  logic          pop,
    output logic [W-1:0]  head,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count_q;
    logic          do_push;
    logic          do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];
    assign count   = count_q;

    // Storage array; contents are don't-care while the slot is empty.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Read/write pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            end
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/chi_rx_chan_recv.sv
// CHI RX channel endpoint: receiver link-active handshake, L-credit issue,
// flit and control parity checking, and a credit-sized flit buffer.
module chi_rx_chan_recv
    import chi_link_pkg::*;
#(
    parameter int WFLIT   = 128,
    parameter int NB      = (WFLIT / 8) + ((WFLIT % 8 != 0) ? 1 : 0),
    parameter int NCRD    = CHI_MAX_CRD,
    parameter int OPC_LSB = 0,
    parameter int OPC_W   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             link_active_req,
    input  logic             link_active_req_chk,
    output logic             link_active_ack,
    output logic             link_active_ack_chk,
    input  logic             flit_pend,
    input  logic             flit_pend_chk,
    input  logic             flitv,
    input  logic             flitv_chk,
    input  logic [WFLIT-1:0] flit,
    input  logic [NB-1:0]    flit_chk,
    output logic             lcrdv,
    output logic             lcrdv_chk,
    output logic             out_valid,
    output logic [WFLIT-1:0] out_flit,
    output logic             out_perr,
    input  logic             out_ready,
    output logic             par_err,
    output logic             proto_err,
    input  logic             err_clr,
    output logic [3:0]       crd_out
);

    localparam int CW = $clog2(NCRD + 1);

    localparam logic [1:0] ST_STOP  = STOP;
    localparam logic [1:0] ST_ACT   = ACT;
    localparam logic [1:0] ST_RUN   = RUN;
    localparam logic [1:0] ST_DEACT = DEACT;

    logic [1:0]      state;
    logic [1:0]      state_nxt;
    logic            ack_q;
    logic            ack_nxt;
    logic            ack_chk_q;
    logic            lcrdv_q;
    logic            lcrdv_chk_q;
    logic [3:0]      crd_q;
    logic            par_q;
    logic            proto_q;

    logic [NB*8-1:0] flit_ext;
    logic [NB-1:0]   exp_chk;
    logic            byte_err;
    logic            ctrl_err;
    logic            is_lcrd_ret;
    logic            link_open;
    logic            accept;
    logic            drop;
    logic            push;
    logic            pop;
    logic            issue;
    logic [4:0]      occ;

    logic [WFLIT:0]  head;
    logic [CW-1:0]   count;
    logic            fifo_full;
    logic            fifo_empty;

    // Zero-extend the flit to whole bytes and derive expected check bits.
    always_comb begin
        flit_ext = '0;
        flit_ext[WFLIT-1:0] = flit;
        for (int unsigned i = 0; i < NB; i++) begin
            exp_chk[i] = byte_par(flit_ext[i*8 +: 8]);
        end
    end

    assign byte_err    = flitv && (flit_chk != exp_chk);
    assign ctrl_err    = (flitv_chk == flitv) || (flit_pend_chk == flit_pend) ||
                         (link_active_req_chk == link_active_req);
    assign is_lcrd_ret = (flit[OPC_LSB +: OPC_W] == OPC_W'(LCRD_RETURN_OPC));
    assign link_open   = (state == ST_RUN) || (state == ST_DEACT);
    assign accept      = flitv && link_open && (crd_q != '0);
    assign drop        = flitv && !accept;
    assign push        = accept && !((state == ST_DEACT) && is_lcrd_ret) && !fifo_full;
    assign pop         = !fifo_empty && out_ready;

    // Credits outstanding plus buffered flits, after this cycle's pop.
    assign occ   = 5'(crd_q) + 5'(count) - {4'b0, pop};
    assign issue = (state == ST_RUN) && (occ < 5'(NCRD));

    // Link-active handshake next state; ack changes with the state it encodes.
    always_comb begin
        state_nxt = state;
        ack_nxt   = ack_q;
        case (state)
            ST_STOP: begin
                if (link_active_req) begin
                    state_nxt = ST_ACT;
                end
            end
            ST_ACT: begin
                state_nxt = ST_RUN;
                ack_nxt   = 1'b1;
            end
            ST_RUN: begin
                if (!link_active_req) begin
                    state_nxt = ST_DEACT;
                end
            end
            ST_DEACT: begin
                if ((crd_q == '0) && !flitv) begin
                    state_nxt = ST_STOP;
                    ack_nxt   = 1'b0;
                end
            end
            default: begin
                state_nxt = ST_STOP;
                ack_nxt   = 1'b0;
            end
        endcase
    end

    // Handshake state and registered ack with its check bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_STOP;
            ack_q     <= 1'b0;
            ack_chk_q <= 1'b1;
        end else begin
            state     <= state_nxt;
            ack_q     <= ack_nxt;
            ack_chk_q <= ~ack_nxt;
        end
    end

    // Credit pulse, outstanding-credit count and sticky error flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lcrdv_q     <= 1'b0;
            lcrdv_chk_q <= 1'b1;
            crd_q       <= '0;
            par_q       <= 1'b0;
            proto_q     <= 1'b0;
        end else begin
            lcrdv_q     <= issue;
            lcrdv_chk_q <= ~issue;
            crd_q       <= crd_q + {3'b0, issue} - {3'b0, accept};
            par_q       <= ctrl_err || byte_err || (par_q && !err_clr);
            proto_q     <= drop || (proto_q && !err_clr);
        end
    end

    chi_rx_fifo #(
        .DEPTH (NCRD),
        .W     (WFLIT + 1)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data ({byte_err, flit}),
        .pop       (pop),
        .head      (head),
        .count     (count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign link_active_ack     = ack_q;
    assign link_active_ack_chk = ack_chk_q;
    assign lcrdv               = lcrdv_q;
    assign lcrdv_chk           = lcrdv_chk_q;
    assign crd_out             = crd_q;
    assign par_err             = par_q;
    assign proto_err           = proto_q;
    assign out_valid           = !fifo_empty;
    assign out_flit            = head[WFLIT-1:0];
    assign out_perr            = head[WFLIT];

endmodule

// File: tb/tb_chi_rx_chan_recv.sv
// Self-checking bench for chi_rx_chan_recv: directed vector table,
// hand-written multi-cycle sequences and a randomized run against a
// queue-based reference model.
module tb_chi_rx_chan_recv;

    localparam int W    = 20;
    localparam int NB   = 3;
    localparam int NCRD = 15;

    localparam int M_STOP  = 0;
    localparam int M_ACT   = 1;
    localparam int M_RUN   = 2;
    localparam int M_DEACT = 3;

    logic          clk;
    logic          rst_n;
    logic          link_active_req;
    logic          link_active_req_chk;
    logic          link_active_ack;
    logic          link_active_ack_chk;
    logic          flit_pend;
    logic          flit_pend_chk;
    logic          flitv;
    logic          flitv_chk;
    logic [W-1:0]  flit;
    logic [NB-1:0] flit_chk;
    logic          lcrdv;
    logic          lcrdv_chk;
    logic          out_valid;
    logic [W-1:0]  out_flit;
    logic          out_perr;
    logic          out_ready;
    logic          par_err;
    logic          proto_err;
    logic          err_clr;
    logic [3:0]    crd_out;

    // Corruption masks: bad_ctl = {req_chk, pend_chk, flitv_chk}
    logic [2:0]    bad_byte;
    logic [2:0]    bad_ctl;

    int checks = 0;
    int errors = 0;

    // Reference model state
    typedef logic [W:0] ent_t;
    int   m_st;
    bit   m_ack;
    bit   m_lcrdv;
    int   m_crd;
    ent_t m_q[$];
    bit   m_par;
    bit   m_proto;

    typedef struct {
        logic         req;
        logic         fv;
        logic [W-1:0] f;
        logic         rdy;
        logic         clr;
        logic [2:0]   bb;
        logic [2:0]   bc;
        logic         e_ack;
        logic         e_lcrdv;
        int           e_crd;
        logic         e_valid;
        logic         e_perr;
        logic         e_par;
        logic         e_proto;
    } vec_t;

    vec_t tbl[$];

    chi_rx_chan_recv #(
        .WFLIT   (W),
        .NCRD    (NCRD),
        .OPC_LSB (0),
        .OPC_W   (4)
    ) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .link_active_req     (link_active_req),
        .link_active_req_chk (link_active_req_chk),
        .link_active_ack     (link_active_ack),
        .link_active_ack_chk (link_active_ack_chk),
        .flit_pend           (flit_pend),
        .flit_pend_chk       (flit_pend_chk),
        .flitv               (flitv),
        .flitv_chk           (flitv_chk),
        .flit                (flit),
        .flit_chk            (flit_chk),
        .lcrdv               (lcrdv),
        .lcrdv_chk           (lcrdv_chk),
        .out_valid           (out_valid),
        .out_flit            (out_flit),
        .out_perr            (out_perr),
        .out_ready           (out_ready),
        .par_err             (par_err),
        .proto_err           (proto_err),
        .err_clr             (err_clr),
        .crd_out             (crd_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    // Odd-parity check bits by counting ones per (zero-extended) byte
    function automatic logic [NB-1:0] good_chk(input logic [W-1:0] f);
        int ones [NB];
        logic [NB-1:0] r;
        for (int i = 0; i < NB; i++) ones[i] = 0;
        for (int b = 0; b < W; b++) if (f[b]) ones[b / 8]++;
        for (int i = 0; i < NB; i++) r[i] = (ones[i] % 2 == 0);
        return r;
    endfunction

    function automatic vec_t mk(input logic req, input logic fv, input logic [W-1:0] f,
                                input logic rdy, input logic clr, input logic [2:0] bb,
                                input logic [2:0] bc, input logic e_ack, input logic e_lcrdv,
                                input int e_crd, input logic e_valid, input logic e_perr,
                                input logic e_par, input logic e_proto);
        vec_t v;
        v.req = req; v.fv = fv; v.f = f; v.rdy = rdy; v.clr = clr; v.bb = bb; v.bc = bc;
        v.e_ack = e_ack; v.e_lcrdv = e_lcrdv; v.e_crd = e_crd; v.e_valid = e_valid;
        v.e_perr = e_perr; v.e_par = e_par; v.e_proto = e_proto;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_idle(input logic r);
        link_active_req = r;
        flit_pend       = 1'b0;
        flitv           = 1'b0;
        flit            = '0;
        out_ready       = 1'b0;
        err_clr         = 1'b0;
        bad_byte        = '0;
        bad_ctl         = '0;
    endtask

    task automatic drive();
        link_active_req_chk = ~link_active_req ^ bad_ctl[2];
        flit_pend_chk       = ~flit_pend ^ bad_ctl[1];
        flitv_chk           = ~flitv ^ bad_ctl[0];
        flit_chk            = good_chk(flit) ^ bad_byte;
    endtask

    task automatic model_reset();
        m_st = M_STOP; m_ack = 0; m_lcrdv = 0; m_crd = 0; m_par = 0; m_proto = 0;
        m_q.delete();
    endtask

    task automatic compare_model();
        check("ack", link_active_ack, m_ack);
        check("ack_chk", link_active_ack_chk, !m_ack);
        check("lcrdv", lcrdv, m_lcrdv);
        check("lcrdv_chk", lcrdv_chk, !m_lcrdv);
        check("crd_out", crd_out, m_crd);
        check("par_err", par_err, m_par);
        check("proto_err", proto_err, m_proto);
        check("out_valid", out_valid, m_q.size() > 0);
        if (m_q.size() > 0) begin
            check("out_flit", out_flit, m_q[0][W-1:0]);
            check("out_perr", out_perr, m_q[0][W]);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_ack"}, link_active_ack, 0);
        check({tag, "_ack_chk"}, link_active_ack_chk, 1);
        check({tag, "_lcrdv"}, lcrdv, 0);
        check({tag, "_lcrdv_chk"}, lcrdv_chk, 1);
        check({tag, "_valid"}, out_valid, 0);
        check({tag, "_par"}, par_err, 0);
        check({tag, "_proto"}, proto_err, 0);
        check({tag, "_crd"}, crd_out, 0);
    endtask

    // One clock: model next state from current inputs, then compare after the edge
    task automatic step();
        bit pop, acc, keep, iss, byt_bad, ctl_bad, clr_s, nack;
        int nst;
        drive();
        pop     = (m_q.size() > 0) && out_ready;
        byt_bad = flitv && (bad_byte != 0);
        ctl_bad = (bad_ctl != 0);
        clr_s   = err_clr;
        iss     = (m_st == M_RUN) && ((m_crd + m_q.size() - int'(pop)) < NCRD);
        acc     = flitv && (m_crd > 0) && (m_st == M_RUN || m_st == M_DEACT);
        keep    = acc && !(m_st == M_DEACT && flit[3:0] == 4'h0);
        nst     = m_st;
        nack    = m_ack;
        case (m_st)
            M_STOP:  if (link_active_req) nst = M_ACT;
            M_ACT:   begin nst = M_RUN; nack = 1; end
            M_RUN:   if (!link_active_req) nst = M_DEACT;
            default: if (m_crd == 0 && !flitv) begin nst = M_STOP; nack = 0; end
        endcase
        m_proto = (flitv && !acc) || (m_proto && !clr_s);
        m_par   = ctl_bad || byt_bad || (m_par && !clr_s);
        if (pop) void'(m_q.pop_front());
        if (keep) m_q.push_back({byt_bad, flit});
        m_crd   = m_crd + int'(iss) - int'(acc);
        m_lcrdv = iss;
        m_st    = nst;
        m_ack   = nack;
        @(posedge clk);
        #1;
        compare_model();
    endtask

    initial begin
        rst_n = 1'b0;
        set_idle(0);
        drive();
        model_reset();

        // Bring-up timeline, then parity corner cases
        tbl.push_back(mk(1, 0, '0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, '0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        for (int i = 1; i <= 15; i++)
            tbl.push_back(mk(1, 0, '0, 0, 0, 0, 0, 1, 1, i, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, '0, 0, 0, 0, 0, 1, 0, 15, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 20'h00001, 0, 0, 3'b001, 0, 1, 0, 14, 1, 1, 1, 0));
        tbl.push_back(mk(1, 0, '0, 1, 1, 0, 0, 1, 1, 15, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, '0, 0, 0, 0, 0, 1, 0, 15, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, '0, 0, 0, 0, 3'b001, 1, 0, 15, 0, 0, 1, 0));
        tbl.push_back(mk(1, 0, '0, 0, 1, 0, 0, 1, 0, 15, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 20'hABCD5, 0, 0, 0, 0, 1, 0, 14, 1, 0, 0, 0));
        tbl.push_back(mk(1, 0, '0, 1, 0, 0, 0, 1, 1, 15, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 20'hF0F03, 0, 0, 3'b100, 0, 1, 0, 14, 1, 1, 1, 0));
        tbl.push_back(mk(1, 0, '0, 1, 1, 0, 0, 1, 1, 15, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, '0, 0, 0, 0, 0, 1, 0, 15, 0, 0, 0, 0));

        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("rst");
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            set_idle(tbl[i].req);
            flitv     = tbl[i].fv;
            flit      = tbl[i].f;
            out_ready = tbl[i].rdy;
            err_clr   = tbl[i].clr;
            bad_byte  = tbl[i].bb;
            bad_ctl   = tbl[i].bc;
            step();
            check($sformatf("tbl%0d_ack", i), link_active_ack, tbl[i].e_ack);
            check($sformatf("tbl%0d_lcrdv", i), lcrdv, tbl[i].e_lcrdv);
            check($sformatf("tbl%0d_crd", i), crd_out, tbl[i].e_crd);
            check($sformatf("tbl%0d_valid", i), out_valid, tbl[i].e_valid);
            if (tbl[i].e_valid) check($sformatf("tbl%0d_perr", i), out_perr, tbl[i].e_perr);
            check($sformatf("tbl%0d_par", i), par_err, tbl[i].e_par);
            check($sformatf("tbl%0d_proto", i), proto_err, tbl[i].e_proto);
        end

        // Backpressure: fill all 15 slots, then a single pop frees one credit
        for (int i = 0; i < 15; i++) begin
            set_idle(1);
            flitv = 1'b1;
            flit  = {16'($urandom), 4'(i + 1)};
            step();
            check("bp_no_lcrdv", lcrdv, 0);
        end
        check("bp_crd_zero", crd_out, 0);
        check("bp_valid", out_valid, 1);
        set_idle(1);
        out_ready = 1'b1;
        step();
        check("bp_pop_lcrdv", lcrdv, 1);
        check("bp_pop_crd", crd_out, 1);
        set_idle(1);
        step();
        check("bp_single_lcrdv", lcrdv, 0);
        set_idle(1);
        out_ready = 1'b1;
        repeat (20) step();
        check("bp_drain_crd", crd_out, 15);
        check("bp_drain_valid", out_valid, 0);

        // Deactivation with 3 credits outstanding, returned as LCrdReturn flits
        for (int i = 0; i < 12; i++) begin
            set_idle(1);
            flitv = 1'b1;
            flit  = {16'($urandom), 4'h9};
            step();
        end
        check("deact_crd3", crd_out, 3);
        set_idle(0);
        step();
        check("deact_ack_held", link_active_ack, 1);
        for (int i = 0; i < 12; i++) begin
            set_idle(0);
            out_ready = 1'b1;
            step();
            check("deact_no_lcrdv", lcrdv, 0);
        end
        for (int i = 0; i < 3; i++) begin
            set_idle(0);
            flitv = 1'b1;
            flit  = {16'($urandom), 4'h0};
            step();
            check("deact_ret_unbuffered", out_valid, 0);
        end
        check("deact_crd0", crd_out, 0);
        set_idle(0);
        step();
        check("deact_ack_low", link_active_ack, 0);

        // Flit while link is stopped and no credit is outstanding
        set_idle(0);
        flitv = 1'b1;
        flit  = 20'h12345;
        step();
        check("proto_set", proto_err, 1);
        check("proto_dropped", out_valid, 0);
        set_idle(0);
        err_clr = 1'b1;
        step();
        check("proto_clr", proto_err, 0);

        // Reset asserted mid-transfer with buffered flits and a parity error
        set_idle(1);
        repeat (20) step();
        for (int i = 0; i < 3; i++) begin
            set_idle(1);
            flitv = 1'b1;
            flit  = {16'($urandom), 4'h7};
            step();
        end
        set_idle(1);
        bad_ctl = 3'b010;
        step();
        check("mid_par_set", par_err, 1);
        set_idle(1);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_vals("async_rst");
        model_reset();
        @(posedge clk);
        #1;
        check_reset_vals("held_rst");
        rst_n = 1'b1;

        // Randomized traffic against the reference model
        for (int n = 0; n < 3000; n++) begin
            set_idle(0);
            case (m_st)
                M_STOP, M_ACT: link_active_req = ($urandom_range(0, 9) != 0);
                M_RUN:         link_active_req = ($urandom_range(0, 149) != 0);
                default:       link_active_req = 1'($urandom_range(0, 1));
            endcase
            if ((m_crd > 0 && $urandom_range(0, 1) == 1) || $urandom_range(0, 99) == 0) begin
                flitv = 1'b1;
                flit  = 20'($urandom);
                if (m_st == M_DEACT && $urandom_range(0, 9) < 7) flit[3:0] = 4'h0;
            end
            flit_pend = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 9) < 6);
            err_clr   = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 29) == 0) bad_byte = 3'($urandom_range(1, 7));
            if ($urandom_range(0, 49) == 0) bad_ctl = 3'($urandom_range(1, 7));
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
